// File: rtl/seq_scan_pkg.sv
// Shared types and default parameters for the serial pattern scanner.
package seq_scan_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefPatW  = 6;
  // The MSB is the first bit received.
  localparam logic [DefPatW-1:0] DefPattern = 6'b110011;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StReport
  } state_e;

endpackage

// File: rtl/seq_match_core.sv
// Overlapping sequence detector: keeps the recent bit history and how many valid bits it holds.
module seq_match_core import seq_scan_pkg::*; #(
  parameter int unsigned         PAT_W   = DefPatW,
  parameter logic [PAT_W-1:0]    PATTERN = DefPattern
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_en,
  input  logic bit_in,
  input  logic clr,
  output logic hit
);

  localparam int unsigned CntW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;

  // History after the incoming bit, with a saturating fill count.
  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bit_in};
    cnt_inc    = (cnt_q == CntW'(PAT_W)) ? cnt_q : cnt_q + CntW'(1);
    hit        = bit_en && !clr && (hist_shift == PATTERN) && (cnt_inc >= CntW'(PAT_W));
    hist_d     = hist_q;
    cnt_d      = cnt_q;
    if (clr) begin
      hist_d = '0;
      cnt_d  = '0;
    end else if (bit_en) begin
      hist_d = hist_shift;
      cnt_d  = cnt_inc;
    end
  end

  // History state; never cleared on a match so detection overlaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts a word, serialises it LSB first into the detector, and reports the match count.
module seq_scan_ctrl import seq_scan_pkg::*; #(
  parameter int unsigned         DATA_W  = DefDataW,
  parameter int unsigned         PAT_W   = DefPatW,
  parameter logic [PAT_W-1:0]    PATTERN = DefPattern
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_chain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_count,
  output logic              ser_bit,
  output logic              match
);

  localparam int unsigned IdxW = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              match_q, match_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              core_clr, core_en, core_bit, core_hit;

  seq_match_core #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .bit_en (core_en),
    .bit_in (core_bit),
    .clr    (core_clr),
    .hit    (core_hit)
  );

  // Next-state logic for the IDLE -> SHIFT -> REPORT sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    match_d     = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    core_clr    = 1'b0;
    core_en     = 1'b0;
    core_bit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          word_d     = in_data;
          idx_d      = '0;
          cnt_d      = '0;
          // Unchained words start with an empty history.
          core_clr   = !in_chain;
          in_ready_d = 1'b0;
          state_d    = StShift;
        end
      end
      StShift: begin
        core_en  = 1'b1;
        core_bit = word_q[idx_q];
        match_d  = core_hit;
        if (core_hit && (cnt_q != 5'(DATA_W))) begin
          cnt_d = cnt_q + 5'd1;
        end
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(DATA_W - 1)) begin
          state_d = StReport;
        end
      end
      StReport: begin
        // out_valid rises one cycle into REPORT and holds until consumed.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state and registered handshake/match outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      match_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = cnt_q;
  assign match     = match_q;
  assign ser_bit   = core_bit;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl with hand-computed match counts.
module tb_seq_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_chain = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, ser_bit, match;
  logic [4:0]  out_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_chain  (in_chain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .ser_bit   (ser_bit),
    .match     (match)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a word; returns 1ns after the accepting edge.
  task automatic send(input string tag, input logic [15:0] d, input logic ch);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_chain = ch;
    step();
    in_valid = 1'b0;
  endtask

  // Watches the word through SHIFT until out_valid, checking bits, pulses and latency.
  task automatic collect(input string tag, input logic [15:0] d, input logic [4:0] exp_cnt,
                         input int exp_pulses);
    logic [15:0] sv = '0;
    int          pulses = 0;
    int          lat = -1;
    logic        ir_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k < 16) sv[k] = ser_bit;
      if (match) pulses++;
      if (in_ready) ir_seen = 1'b1;
      if (out_valid) begin
        lat = k;
        break;
      end
      step();
    end
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_count"}, {27'd0, out_count}, {27'd0, exp_cnt});
    chk({tag, "_pulses"}, pulses, exp_pulses);
    chk({tag, "_serbits"}, {16'd0, sv}, {16'd0, d});
    chk({tag, "_ser_idle"}, ser_bit, 0);
    chk({tag, "_busy"}, ir_seen, 0);
  endtask

  // Consumes the result with out_ready high and checks the return to IDLE.
  task automatic finish_word(input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, "_ov_clear"}, out_valid, 0);
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  task automatic run_word(input string tag, input logic [15:0] d, input logic ch,
                          input logic [4:0] exp_cnt, input int exp_pulses);
    send(tag, d, ch);
    collect(tag, d, exp_cnt, exp_pulses);
    finish_word(tag);
  endtask

  initial begin
    logic stall_bad;

    // Reset state while reset is held low.
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_match", match, 0);
    chk("rst_ser_bit", ser_bit, 0);
    chk("rst_count", {27'd0, out_count}, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rst_release_ready", in_ready, 1);

    // Single match, then overlapping matches at idx 5 and 9.
    run_word("w0033", 16'h0033, 1'b0, 5'd1, 1);
    run_word("w0333", 16'h0333, 1'b0, 5'd2, 2);

    // Pattern split across two words: counts only when chained.
    run_word("c1a", 16'hC000, 1'b0, 5'd0, 0);
    run_word("c1b", 16'h000C, 1'b1, 5'd1, 1);
    run_word("c0a", 16'hC000, 1'b0, 5'd0, 0);
    run_word("c0b", 16'h000C, 1'b0, 5'd0, 0);

    // Uniform words never match.
    run_word("wffff", 16'hFFFF, 1'b0, 5'd0, 0);
    run_word("w0000", 16'h0000, 1'b0, 5'd0, 0);

    // Consumer stall: 0x3333 matches at idx 5, 9, 13.
    out_ready = 1'b0;
    send("stall", 16'h3333, 1'b0);
    collect("stall", 16'h3333, 5'd3, 3);
    stall_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b1 || out_count !== 5'd3 || in_ready !== 1'b0) stall_bad = 1'b1;
    end
    chk("stall_hold", stall_bad, 0);
    finish_word("stall");

    // Reset in the middle of SHIFT aborts the word.
    send("abort", 16'h0033, 1'b0);
    for (int i = 0; i < 7; i++) step();
    reset = 1'b0;
    #1;
    chk("abort_ser_bit", ser_bit, 0);
    chk("abort_match", match, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_count", {27'd0, out_count}, 0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("abort_ready", in_ready, 1);
    stall_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) stall_bad = 1'b1;
      step();
    end
    chk("abort_no_valid", stall_bad, 0);
    run_word("post_rst", 16'h0033, 1'b1, 5'd1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
